// File: rtl/key_conditioner.sv
// Push-button front end: synchronise, debounce and derive press/release/long-press events.
// The release event is exposed as release_pulse because "release" is a reserved word.
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_press,
  output logic              any_pressed
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  // long_press is registered, so it is scheduled one count early
  localparam logic [LW-1:0] LG_PRE = LW'(LONG_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE,
    HOLDING,
    LONG
  } hold_t;

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  assign r = ~sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_pressed <= 1'b0;
    else     any_pressed <= |pressed;
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic [DW-1:0] db_cnt;
    logic [LW-1:0] hold_cnt;
    hold_t         st;
    logic          lvl;
    logic          pr;
    logic          rl;
    logic          lp;
    logic          tog;

    assign tog = (r[i] != lvl) && (db_cnt == DB_MAX);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt   <= '0;
        hold_cnt <= '0;
        st       <= IDLE;
        lvl      <= 1'b0;
        pr       <= 1'b0;
        rl       <= 1'b0;
        lp       <= 1'b0;
      end else begin
        pr <= tog & ~lvl;
        rl <= tog & lvl;
        lp <= 1'b0;

        if (r[i] == lvl) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_MAX) begin
          db_cnt <= '0;
          lvl    <= ~lvl;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end

        unique case (st)
          IDLE: begin
            hold_cnt <= '0;
            if (tog && !lvl) st <= HOLDING;
          end
          HOLDING: begin
            if (tog) begin
              st       <= IDLE;
              hold_cnt <= '0;
            end else if (hold_cnt == LG_PRE) begin
              st       <= LONG;
              lp       <= 1'b1;
              hold_cnt <= hold_cnt + 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          LONG: begin
            if (tog) begin
              st       <= IDLE;
              hold_cnt <= '0;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end

    assign pressed[i]       = lvl;
    assign press[i]         = pr;
    assign release_pulse[i] = rl;
    assign long_press[i]    = lp;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic [3:0] pressed;
  logic [3:0] press;
  logic [3:0] release_pulse;
  logic [3:0] long_press;
  logic       any_pressed;

  int tests = 0;
  int fails = 0;
  int pc[4];
  int rc[4];
  int lc[4];
  int overlap = 0;

  key_conditioner #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .pressed(pressed),
    .press(press),
    .release_pulse(release_pulse),
    .long_press(long_press),
    .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 4; k++) begin
      pc[k] = 0;
      rc[k] = 0;
      lc[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (press[k])         pc[k] <= pc[k] + 1;
      if (release_pulse[k]) rc[k] <= rc[k] + 1;
      if (long_press[k])    lc[k] <= lc[k] + 1;
    end
    if ((press & release_pulse) != 4'b0) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int p1, l2, r2, l3;

  initial begin
    rst = 1'b1;
    key = 4'b0000;
    tick(2);
    check("rst_pressed", 32'(pressed), 0);
    check("rst_press", 32'(press), 0);
    check("rst_release", 32'(release_pulse), 0);
    check("rst_long", 32'(long_press), 0);
    check("rst_any", 32'(any_pressed), 0);

    // T1: key0 press, 6 edges after first sampling edge
    rst = 1'b0;
    key = 4'b1110;
    tick(5);
    check("t1_pressed_e4", 32'(pressed), 0);
    tick(1);
    check("t1_pressed_e5", 32'(pressed), 4'b0001);
    check("t1_press_e5", 32'(press), 4'b0001);
    check("t1_any_e5", 32'(any_pressed), 0);
    tick(1);
    check("t1_press_e6", 32'(press), 0);
    check("t1_any_e6", 32'(any_pressed), 1);
    key = 4'b1111;
    tick(5);
    check("t1_rel_e4", 32'(release_pulse), 0);
    tick(1);
    check("t1_rel_e5", 32'(release_pulse), 4'b0001);
    check("t1_unpressed", 32'(pressed), 0);
    tick(1);
    check("t1_rel_e6", 32'(release_pulse), 0);
    check("t1_no_long", 32'(lc[0]), 0);

    // T2: bounces on key1 never accepted
    p1 = pc[1];
    key = 4'b1101; tick(3);
    key = 4'b1111; tick(1);
    key = 4'b1101; tick(3);
    key = 4'b1111; tick(10);
    check("t2_bounce_press", 32'(pc[1] - p1), 0);
    check("t2_bounce_lvl", 32'(pressed), 0);
    key = 4'b1101;
    tick(6);
    check("t2_press", 32'(press), 4'b0010);
    key = 4'b1111;
    tick(4);
    check("t2_single", 32'(pc[1] - p1), 1);
    tick(2);
    check("t2_rel", 32'(release_pulse), 4'b0010);

    // T3: key2 long press fires once, 19 cycles after press
    l2 = lc[2];
    key = 4'b1011;
    tick(6);
    check("t3_press", 32'(press), 4'b0100);
    tick(18);
    check("t3_long_early", 32'(long_press), 0);
    tick(1);
    check("t3_long", 32'(long_press), 4'b0100);
    tick(1);
    check("t3_long_after", 32'(long_press), 0);
    tick(10);
    check("t3_long_once", 32'(lc[2] - l2), 1);
    key = 4'b1111;
    tick(5);
    check("t3_rel_e4", 32'(release_pulse), 0);
    tick(1);
    check("t3_rel", 32'(release_pulse), 4'b0100);

    // T4: key3 short hold, no long press
    l3 = lc[3];
    key = 4'b0111;
    tick(6);
    check("t4_press", 32'(press), 4'b1000);
    tick(10);
    key = 4'b1111;
    tick(6);
    check("t4_rel", 32'(release_pulse), 4'b1000);
    tick(20);
    check("t4_no_long", 32'(lc[3] - l3), 0);

    // T5: all keys at once
    key = 4'b0000;
    tick(6);
    check("t5_press", 32'(press), 4'b1111);
    check("t5_any_lag", 32'(any_pressed), 0);
    tick(1);
    check("t5_any", 32'(any_pressed), 1);
    key = 4'b1111;
    tick(6);
    check("t5_rel", 32'(release_pulse), 4'b1111);
    tick(1);
    check("t5_any_off", 32'(any_pressed), 0);

    // T6: reset while key0 is in the long state
    key = 4'b1110;
    tick(6);
    check("t6_press", 32'(press), 4'b0001);
    tick(19);
    check("t6_long", 32'(long_press), 4'b0001);
    tick(3);
    r2 = rc[0];
    rst = 1'b1;
    #1;
    check("t6_rst_pressed", 32'(pressed), 0);
    check("t6_rst_long", 32'(long_press), 0);
    tick(2);
    check("t6_rst_rel", 32'(release_pulse), 0);
    rst = 1'b0;
    tick(5);
    check("t6_repress_e4", 32'(press), 0);
    tick(1);
    check("t6_repress", 32'(press), 4'b0001);
    tick(19);
    check("t6_relong", 32'(long_press), 4'b0001);
    check("t6_no_rel", 32'(rc[0] - r2), 0);
    check("overlap", 32'(overlap), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
Input-side counterpart to the LED/7-segment output path. It takes the raw active-LOW push-button pins of the RZ-EasyFPGA board and turns them into clean active-HIGH per-key signals: held level, one-cycle press pulse, one-cycle release pulse, and one-cycle long-press pulse. It sits between the board key pins and the traffic-light FSM and replaces direct use of raw key levels.

Parameters:
N_KEYS, 4, number of independent keys conditioned
DEBOUNCE_CYCLES, 1_000_000, consecutive clk cycles a new level must persist before it is accepted (20 ms at 50 MHz); must be >= 2
LONG_CYCLES, 100_000_000, clk cycles a debounced press must be held before long_press fires (2 s at 50 MHz); must be >= 2

Ports:
clk  input  1  system clock, 50 MHz, rising edge
rst  input  1  asynchronous, active-HIGH reset
key  input  N_KEYS  raw button pins, active LOW (0 = pressed), asynchronous to clk
pressed  output  N_KEYS  debounced held level, active HIGH
press  output  N_KEYS  one-cycle pulse on debounced press
release  output  N_KEYS  one-cycle pulse on debounced release
long_press  output  N_KEYS  one-cycle pulse, at most once per press
any_pressed  output  1  OR-reduction of pressed, registered

Behaviour:
- Reset: async assert, sync-style deassert taken as given. While rst=1:
  - synchronizer flops = 1 (released);
  - debounce and hold counters = 0;
  - pressed, press, release, long_press, any_pressed = 0.
- Synchronizer: two flops per key, then r[i] = ~sync2[i] (active HIGH).
- Debounce (per key, independent):
  - If r[i] == pressed[i], the counter clears to 0.
  - Otherwise, if the counter == DEBOUNCE_CYCLES-1, pressed[i] toggles and the counter clears. Else the counter increments.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count; no change is accepted.
  - Counter width is $clog2(DEBOUNCE_CYCLES); no wrap is possible.
- Latency: pin held low from the edge that first samples it (edge 0). pressed[i] and press[i] are high after edge DEBOUNCE_CYCLES+1. Release has the same latency.
- press[i] = 1 for exactly the cycle in which pressed[i] first reads 1. release[i] = 1 for exactly the cycle in which pressed[i] first reads 0. press and release are registered, never both high for the same key.
- Per-key hold state: IDLE -> HOLDING on press. HOLDING -> LONG on hold counter == LONG_CYCLES-1, asserting long_press[i] for that one cycle. HOLDING or LONG -> IDLE on release.
  - Hold counter counts cycles with pressed[i]=1 in HOLDING, starting at 0 in the cycle press fires. long_press therefore fires LONG_CYCLES-1 cycles after press.
  - In LONG the counter is frozen; no further long_press until a new press.
  - Hold counter clears in IDLE. Release before the threshold gives no long_press.
- Simultaneous events: keys are fully independent; several press/release/long_press bits may assert in the same cycle.
- any_pressed: registered OR of pressed; one cycle behind pressed.
- Reset mid-operation: all state clears immediately; no release pulse is generated. A key still held at deassert is re-debounced and produces a fresh press after DEBOUNCE_CYCLES+2 edges.

Test Plan:
(use DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
1. rst=1, key=4'b0000 -> all outputs 0. rst->0, key held 4'b1110 -> pressed[0]=1 and press[0]=1 for one cycle, 6 edges after the first sampling edge; other bits stay 0.
2. key[1] bounces low 3 cycles, high 1, low 3, high -> pressed[1], press[1] never assert. Then low 6 cycles -> a single press[1] pulse.
3. key[2] held low 30 cycles after press -> long_press[2] once, 19 cycles after press, then silent. Release -> release[2] one cycle, 6 edges after pin goes high.
4. key[3] held 10 cycles after press then released -> release[3] pulse; long_press[3] stays 0 throughout.
5. key=4'b0000 simultaneously -> press=4'b1111 in the same cycle; any_pressed=1 one cycle later.
6. key[0] in LONG state, pulse rst=1 for 2 cycles while the pin stays low -> outputs 0 immediately, no release pulse; after deassert, a fresh press[0] after 6 edges and a new long_press[0] 19 cycles later.
